// File: rtl/usb_stream_packer.sv
// Packs capture bytes LSB-first into BUS_BYTES-wide FX2 words; a full word reaches the output register one cycle after its last byte.
// in_ready drops while the last lane would overwrite an unsent word; flush pads the tail word and ends the packet with a PKTEND strobe.
module usb_stream_packer #(
   parameter int          BUS_BYTES     = 2,
   parameter int          FLUSH_TIMEOUT = 4096,
   parameter logic [7:0]  PAD_BYTE      = 8'h00,
   parameter logic [15:0] RNG_SEED      = 16'h6c41
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [7:0]             in_data_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic                   flush_i,
   input  logic [1:0]             test_mode_i,
   output logic [8*BUS_BYTES-1:0] out_data_o,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic                   out_pktend_o,
   output logic                   busy_o
);
   localparam int W     = 8*BUS_BYTES;
   localparam int LANES = BUS_BYTES/2;
   localparam int CW    = $clog2(BUS_BYTES);
   localparam int IW    = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT+1) : 1;

   typedef enum logic [1:0] {FILL, WORD, PKTEND, TEST} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt_q, cnt_nx;
   logic [W-1:0]    asm_q, asm_nx, asm_new;
   logic [W-1:0]    data_nx, pcnt_q, pcnt_nx;
   logic [W-1:0]    pat_cur, pat_adv;
   logic [15:0]     rng_q, rng_nx, rng_adv;
   logic [IW-1:0]   idle_q, idle_nx;
   logic            valid_nx, pktend_nx, ready_nx;
   logic            sent_q, sent_nx, fpend_q, fpend_nx;
   logic            acc, last, fire, timeout, flush_ev;
   logic [1:0]      tm;
   int              cnt_eff;

   function automatic logic [15:0] xs_step(input logic [15:0] s);
      logic [15:0] t;
      t = s ^ (s << 7);
      t = t ^ (t >> 9);
      t = t ^ (t << 8);
      return t;
   endfunction

   function automatic logic [15:0] xs_n(input logic [15:0] s, input int n);
      logic [15:0] t;
      t = s;
      for (int i = 0; i < 8; i++)
         if (i < n) t = xs_step(t);
      return t;
   endfunction

   // Lane k of a pattern word is the seed state advanced k+1 steps.
   always_comb begin
      pat_cur = '0;
      pat_adv = '0;
      for (int k = 0; k < LANES; k++) begin
         pat_cur[16*k +: 16] = xs_n(rng_q, k+1);
         pat_adv[16*k +: 16] = xs_n(rng_q, LANES+k+1);
      end
   end
   assign rng_adv = xs_n(rng_q, LANES);

   assign busy_o = (state == WORD) || (state == PKTEND) ||
                   ((state == FILL) && ((cnt_q != '0) || out_valid_o || sent_q));

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt_q;
      asm_nx    = asm_q;
      data_nx   = out_data_o;
      valid_nx  = out_valid_o;
      sent_nx   = sent_q;
      fpend_nx  = fpend_q;
      rng_nx    = rng_q;
      pcnt_nx   = pcnt_q;
      idle_nx   = idle_q;
      tm        = (test_mode_i == 2'b11) ? 2'b00 : test_mode_i;
      acc       = in_valid_i && in_ready_o;
      last      = (cnt_q == CW'(BUS_BYTES-1));
      fire      = out_valid_o && out_ready_i;
      timeout   = (FLUSH_TIMEOUT != 0) && (idle_q == IW'(FLUSH_TIMEOUT));
      flush_ev  = flush_i || fpend_q || timeout;
      cnt_eff   = int'(cnt_q) + int'(acc);
      asm_new   = asm_q;
      if (acc) asm_new[{cnt_q, 3'b000} +: 8] = in_data_i;

      case (state)
         FILL: begin
            fpend_nx = 1'b0;
            asm_nx   = asm_new;
            if (acc) cnt_nx = last ? '0 : cnt_q + CW'(1);
            if (fire) valid_nx = 1'b0;
            if (acc && last) begin
               data_nx  = asm_new;
               valid_nx = 1'b1;
               sent_nx  = 1'b1;
            end
            if (flush_ev) begin
               if (acc && last) begin
                  state_nx = PKTEND;
               end else if (cnt_eff != 0) begin
                  for (int k = 0; k < BUS_BYTES; k++)
                     if (k >= cnt_eff) asm_nx[8*k +: 8] = PAD_BYTE;
                  state_nx = WORD;
               end else if (sent_q) begin
                  state_nx = PKTEND;
               end
            end else if (tm != 2'b00 && cnt_q == '0 && !out_valid_o && !acc) begin
               state_nx = TEST;
            end
         end
         WORD: begin
            if (flush_i) fpend_nx = 1'b1;
            // Non-zero count means the padded word is still waiting for the output register.
            if (cnt_q != '0) begin
               if (!out_valid_o || out_ready_i) begin
                  data_nx  = asm_q;
                  valid_nx = 1'b1;
                  cnt_nx   = '0;
                  sent_nx  = 1'b1;
               end
            end else if (fire) begin
               valid_nx = 1'b0;
               state_nx = PKTEND;
            end
         end
         PKTEND: begin
            if (flush_i) fpend_nx = 1'b1;
            if (fire) valid_nx = 1'b0;
            if (out_pktend_o && out_ready_i) begin
               state_nx = FILL;
               sent_nx  = 1'b0;
            end
         end
         default: begin
            if (tm == 2'b00) begin
               state_nx = FILL;
               valid_nx = 1'b0;
               rng_nx   = RNG_SEED;
               pcnt_nx  = '0;
            end else if (!out_valid_o) begin
               valid_nx = 1'b1;
               data_nx  = (tm == 2'b01) ? pat_cur : pcnt_q;
            end else if (out_ready_i) begin
               if (tm == 2'b01) begin
                  rng_nx  = rng_adv;
                  data_nx = pat_adv;
               end else begin
                  pcnt_nx = pcnt_q + W'(1);
                  data_nx = pcnt_q + W'(1);
               end
            end
         end
      endcase

      if (FLUSH_TIMEOUT == 0 || acc || state_nx == PKTEND)
         idle_nx = '0;
      else if (busy_o && idle_q != IW'(FLUSH_TIMEOUT))
         idle_nx = idle_q + IW'(1);

      pktend_nx = (state_nx == PKTEND) && !valid_nx;
      ready_nx  = (state_nx == FILL) && !((cnt_nx == CW'(BUS_BYTES-1)) && valid_nx);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state        <= FILL;
         cnt_q        <= '0;
         asm_q        <= '0;
         out_data_o   <= '0;
         out_valid_o  <= 1'b0;
         out_pktend_o <= 1'b0;
         in_ready_o   <= 1'b0;
         sent_q       <= 1'b0;
         fpend_q      <= 1'b0;
         rng_q        <= RNG_SEED;
         pcnt_q       <= '0;
         idle_q       <= '0;
      end else begin
         state        <= state_nx;
         cnt_q        <= cnt_nx;
         asm_q        <= asm_nx;
         out_data_o   <= data_nx;
         out_valid_o  <= valid_nx;
         out_pktend_o <= pktend_nx;
         in_ready_o   <= ready_nx;
         sent_q       <= sent_nx;
         fpend_q      <= fpend_nx;
         rng_q        <= rng_nx;
         pcnt_q       <= pcnt_nx;
         idle_q       <= idle_nx;
      end
   end
endmodule

// File: tb/tb_usb_stream_packer.sv
// Directed bench for usb_stream_packer (BUS_BYTES=2, FLUSH_TIMEOUT=8); a negedge monitor logs word and pktend handshakes in order.
module tb_usb_stream_packer;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid, in_ready, flush;
   logic [1:0]  test_mode;
   logic [15:0] out_data;
   logic        out_valid, out_ready, pktend, busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int t0;
   logic [16:0] ev_q[$];
   localparam logic [16:0] PKT = 17'h10000;

   usb_stream_packer #(.BUS_BYTES(2), .FLUSH_TIMEOUT(8), .PAD_BYTE(8'h00), .RNG_SEED(16'h6c41)) dut (
      .clk_i(clk), .reset_i(rst), .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .flush_i(flush), .test_mode_i(test_mode), .out_data_o(out_data), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .out_pktend_o(pktend), .busy_o(busy));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) ev_q.push_back({1'b0, out_data});
         if (pktend && out_ready) ev_q.push_back(PKT);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] d);
      int   n = 0;
      logic hs;
      in_valid = 1'b1;
      in_data  = d;
      do begin
         hs = in_ready;
         tick();
         n++;
      end while (!hs && n < 40);
      if (!hs) begin
         n_cmp++;
         n_bad++;
         $error("FAIL send: byte %h not accepted within %0d cycles", d, n);
      end
   endtask

   task automatic expect_ev(input string tag, input logic [16:0] exp);
      int n = 0;
      while (ev_q.size() == 0 && n < 60) begin
         tick();
         n++;
      end
      if (ev_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL %s: no event within %0d cycles, expected %h", tag, n, exp);
      end else begin
         check(tag, 32'(ev_q.pop_front()), 32'(exp));
      end
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check(tag, 32'(out_valid), 32'd1);
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; flush = 1'b0; test_mode = 2'b00; out_ready = 1'b1;
      repeat (3) tick();
      check("rst in_ready", 32'(in_ready), 32'd0);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst pktend", 32'(pktend), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst out_data", 32'(out_data), 32'd0);
      rst = 1'b0;
      tick(); tick();
      check("ready after rst", 32'(in_ready), 32'd1);

      // full-rate streaming
      t0 = cyc;
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      in_valid = 1'b0;
      check("t1 no stall", 32'(cyc - t0), 32'd4);
      expect_ev("t1 word0", 17'h02211);
      expect_ev("t1 word1", 17'h04433);
      pulse_flush();
      expect_ev("t1 pktend", PKT);
      tick();
      check("t1 pktend one cycle", 32'(pktend), 32'd0);
      check("t1 busy drop", 32'(busy), 32'd0);
      pulse_flush();
      repeat (10) tick();
      check("empty flush ignored", 32'(ev_q.size()), 32'd0);

      // partial word padded on flush
      send(8'hAA); send(8'hBB); send(8'hCC);
      in_valid = 1'b0;
      pulse_flush();
      expect_ev("t2 word0", 17'h0BBAA);
      expect_ev("t2 padded", 17'h000CC);
      expect_ev("t2 pktend", PKT);
      tick();
      check("t2 busy drop", 32'(busy), 32'd0);

      // byte and flush in the same cycle
      flush = 1'b1; send(8'hDD); flush = 1'b0; in_valid = 1'b0;
      expect_ev("same-cycle partial", 17'h000DD);
      expect_ev("same-cycle partial pkt", PKT);
      send(8'hEE);
      flush = 1'b1; send(8'hFF); flush = 1'b0; in_valid = 1'b0;
      expect_ev("same-cycle full", 17'h0FFEE);
      expect_ev("same-cycle full pkt", PKT);

      // idle timeout
      send(8'h5A);
      in_valid = 1'b0;
      repeat (6) tick();
      check("t3 no early flush", 32'(ev_q.size()), 32'd0);
      expect_ev("t3 padded", 17'h0005A);
      expect_ev("t3 pktend", PKT);
      repeat (100) tick();
      check("t3 no second pktend", 32'(ev_q.size()), 32'd0);

      // backpressure
      out_ready = 1'b0;
      send(8'h01); send(8'h02);
      check("t4 pending valid", 32'(out_valid), 32'd1);
      check("t4 pending data", 32'(out_data), 32'h0201);
      send(8'h03);
      check("t4 ready drop", 32'(in_ready), 32'd0);
      in_data = 8'h04;
      tick(); tick();
      check("t4 ready held", 32'(in_ready), 32'd0);
      check("t4 data held", 32'(out_data), 32'h0201);
      out_ready = 1'b1;
      send(8'h04);
      in_valid = 1'b0;
      expect_ev("t4 word0", 17'h00201);
      expect_ev("t4 word1", 17'h00403);
      pulse_flush();
      expect_ev("t4 pktend", PKT);
      repeat (3) tick();
      check("t4 no duplicate", 32'(ev_q.size()), 32'd0);

      // xorshift pattern
      test_mode = 2'b01;
      wait_valid("t5 valid");
      for (int i = 0; i < 3; i++) begin
         check("t5 one per cycle", 32'(out_valid), 32'd1);
         check("t5 ready low", 32'(in_ready), 32'd0);
         tick();
      end
      expect_ev("t5 xs0", 17'h0abe7);
      expect_ev("t5 xs1", 17'h0134b);
      expect_ev("t5 xs2", 17'h02690);
      test_mode = 2'b00;
      tick(); tick();
      ev_q.delete();
      check("t5 exit valid", 32'(out_valid), 32'd0);
      test_mode = 2'b01;
      wait_valid("t5 reentry valid");
      check("t5 reentry data", 32'(out_data), 32'habe7);
      test_mode = 2'b00;
      tick(); tick();

      // counter pattern
      test_mode = 2'b10;
      wait_valid("cnt valid");
      check("cnt word0", 32'(out_data), 32'h0000);
      tick();
      check("cnt word1", 32'(out_data), 32'h0001);
      tick();
      check("cnt word2", 32'(out_data), 32'h0002);
      test_mode = 2'b11;
      tick(); tick();
      check("reserved valid", 32'(out_valid), 32'd0);
      check("reserved ready", 32'(in_ready), 32'd1);
      test_mode = 2'b00;
      tick();
      ev_q.delete();

      // reset mid-partial
      send(8'h77);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("t6 rst busy", 32'(busy), 32'd0);
      check("t6 rst ready", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0;
      tick(); tick();
      send(8'h01); send(8'h02);
      in_valid = 1'b0;
      expect_ev("t6 word", 17'h00201);
      pulse_flush();
      expect_ev("t6 pktend", PKT);
      repeat (3) tick();
      check("t6 quiet", 32'(ev_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
